// File: rtl/iob_rtc_tick_gen_pkg.sv
// ----------------------------------------------------------------------------
// iob_rtc_tick_gen_pkg: CSR map and shared helpers for the RTC tick generator.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package iob_rtc_tick_gen_pkg;

    localparam int DEFAULT_ACC_W = 32;

    localparam logic [1:0] CTRL_ADDR     = 2'd0;
    localparam logic [1:0] INCR_ADDR     = 2'd1;
    localparam logic [1:0] TICK_CNT_ADDR = 2'd2;
    localparam logic [1:0] RSVD_ADDR     = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    function automatic logic [7:0] merge_byte(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       strb
    );
        return strb ? new_byte : old_byte;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iob_rtc_phase_acc.sv
// ----------------------------------------------------------------------------
// iob_rtc_phase_acc: phase accumulator, carry-driven tick/RTC flops, tick counter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module iob_rtc_phase_acc
    import iob_rtc_tick_gen_pkg::*;
#(
    parameter int ACC_W = DEFAULT_ACC_W
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             cke,
    input  logic             en,
    input  logic             clr,
    input  logic [ACC_W-1:0] incr,
    output logic             tick,
    output logic             rtc,
    output logic [31:0]      tick_cnt
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, incr};

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            acc      <= '0;
            tick     <= 1'b0;
            rtc      <= 1'b0;
            tick_cnt <= '0;
        end else if (cke) begin
            // Clear takes priority over a carry landing on the same edge.
            if (clr) begin
                acc      <= '0;
                tick     <= 1'b0;
                rtc      <= 1'b0;
                tick_cnt <= '0;
            end else if (en) begin
                acc  <= sum[ACC_W-1:0];
                tick <= sum[ACC_W];
                if (sum[ACC_W]) begin
                    rtc      <= ~rtc;
                    tick_cnt <= tick_cnt + 32'd1;
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/iob_rtc_tick_gen.sv
// ----------------------------------------------------------------------------
// iob_rtc_tick_gen: IOb CSR slave around a fractional phase-accumulator RTC.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module iob_rtc_tick_gen
    import iob_rtc_tick_gen_pkg::*;
#(
    parameter int               ADDR_W   = 16,
    parameter int               DATA_W   = 32,
    parameter int               ACC_W    = DEFAULT_ACC_W,
    parameter logic [ACC_W-1:0] INCR_RST = '0
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                cke_i,
    input  logic                iob_avalid,
    input  logic [ADDR_W-1:0]   iob_addr,
    input  logic [DATA_W-1:0]   iob_wdata,
    input  logic [DATA_W/8-1:0] iob_wstrb,
    output logic                iob_rvalid,
    output logic [DATA_W-1:0]   iob_rdata,
    output logic                iob_ready,
    output logic                rtc_o,
    output logic                rtc_tick_o
);

    localparam int STRB_W = DATA_W / 8;

    logic              accept;
    logic              is_write;
    logic              rd_accept;
    logic [1:0]        word;
    logic              ctrl_wr;
    logic              incr_wr;
    logic              clr_req;
    logic              en;
    logic [ACC_W-1:0]  incr;
    logic [DATA_W-1:0] incr_wide;
    logic [DATA_W-1:0] incr_merged;
    logic [DATA_W-1:0] rd_mux;
    logic [31:0]       tick_cnt;
    logic              unused_addr;

    assign unused_addr = ^{iob_addr[ADDR_W-1:4], iob_addr[1:0]};

    // Requests presented while cke_i is low are acknowledged but dropped.
    assign iob_ready = 1'b1;
    assign accept    = iob_avalid & cke_i;
    assign is_write  = |iob_wstrb;
    assign rd_accept = accept & ~is_write;
    assign word      = iob_addr[3:2];
    assign ctrl_wr   = accept & is_write & (word == CTRL_ADDR) & iob_wstrb[0];
    assign incr_wr   = accept & is_write & (word == INCR_ADDR);
    assign clr_req   = ctrl_wr & iob_wdata[CTRL_CLR];
    assign incr_wide = DATA_W'(incr);

    generate
        for (genvar b = 0; b < STRB_W; b++) begin : g_byte
            assign incr_merged[8*b +: 8] =
                merge_byte(incr_wide[8*b +: 8], iob_wdata[8*b +: 8], iob_wstrb[b]);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            en   <= 1'b0;
            incr <= INCR_RST;
        end else begin
            if (ctrl_wr) begin
                en <= iob_wdata[CTRL_EN];
            end
            if (incr_wr) begin
                incr <= incr_merged[ACC_W-1:0];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (word)
            CTRL_ADDR:     rd_mux = {{(DATA_W-1){1'b0}}, en};
            INCR_ADDR:     rd_mux = incr_wide;
            TICK_CNT_ADDR: rd_mux = DATA_W'(tick_cnt);
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            iob_rvalid <= 1'b0;
            iob_rdata  <= '0;
        end else if (cke_i) begin
            iob_rvalid <= rd_accept;
            if (rd_accept) begin
                iob_rdata <= rd_mux;
            end
        end
    end

    iob_rtc_phase_acc #(
        .ACC_W (ACC_W)
    ) u_phase_acc (
        .clk      (clk_i),
        .arst_n   (arst_i),
        .cke      (cke_i),
        .en       (en),
        .clr      (clr_req),
        .incr     (incr),
        .tick     (rtc_tick_o),
        .rtc      (rtc_o),
        .tick_cnt (tick_cnt)
    );

endmodule

`default_nettype wire

// File: doc/iob_rtc_tick_gen.md
Name: iob_rtc_tick_gen

Overview:
Generates the real-time-clock reference (`rtc_o`) that drives the CLINT `rt_clk`/`rtc` input. It also provides a matching single-cycle tick enable (`rtc_tick_o`). It is a programmable fractional divider built on a phase accumulator and clocked from the system clock. Software sets the output rate through a small IOb-native CSR slave. It sits directly upstream of the CLINT in the SoC timer path.

Parameters:
- ADDR_W, 16, IOb address width (byte address); only bits [3:2] are decoded.
- DATA_W, 32, IOb data width; 32 is the only supported value.
- ACC_W, 32, phase accumulator and increment width.
- INCR_RST, 32'h0000_0000, reset value of the INCR register.

Ports:
- clk_i  in  1  system clock.
- arst_i  in  1  asynchronous reset, active-low.
- cke_i  in  1  clock enable; when 0, all state holds.
- iob_avalid  in  1  request valid.
- iob_addr  in  ADDR_W  byte address.
- iob_wdata  in  DATA_W  write data.
- iob_wstrb  in  DATA_W/8  byte write strobes; all-zero means read.
- iob_rvalid  out  1  read data valid.
- iob_rdata  out  DATA_W  read data.
- iob_ready  out  1  request accepted.
- rtc_o  out  1  square-wave RTC, fed to CLINT `rt_clk`.
- rtc_tick_o  out  1  one-cycle pulse on each accumulator carry.

Behaviour:
- Reset: asynchronous on `arst_i`=0. Values during reset:
  - acc=0, CTRL=0, INCR=INCR_RST, TICK_CNT=0
  - rtc_o=0, rtc_tick_o=0, iob_rvalid=0, iob_rdata=0
  - iob_ready=1 (tied high after reset release).
- Register map (word offset `iob_addr[3:2]`):
  - 0 CTRL: bit0 EN (RW), bit1 CLR (write-1, self-clearing, reads 0), other bits read 0.
  - 1 INCR: RW, ACC_W bits.
  - 2 TICK_CNT: RO, 32-bit count of carries, wraps at 2^32.
  - 3 reserved: reads 0, writes ignored.
- Writes:
  - Byte-granular via `iob_wstrb`.
  - Take effect on the clock edge that accepts the request; visible to the datapath from the next cycle.
  - Writes to RO or reserved locations are ignored.
- Reads:
  - `iob_rvalid`=1 exactly one cycle after an accepted read, with `iob_rdata` registered.
  - Back-to-back reads are supported, one per cycle.
  - `iob_rdata` holds its value when `iob_rvalid`=0.
- Datapath, per cycle with cke_i=1, EN=1 and CLR not being written:
  - {carry, acc} <= acc + INCR, computed ACC_W+1 bits wide.
  - rtc_tick_o <= carry.
  - If carry: rtc_o <= ~rtc_o and TICK_CNT <= TICK_CNT + 1.
- Rates:
  - Tick rate = f_clk × INCR / 2^ACC_W.
  - rtc_o frequency = tick rate / 2.
  - Latency from carry to output: 1 cycle (registered outputs).
- EN=0: acc, rtc_o and TICK_CNT hold; rtc_tick_o=0 from the next cycle.
- INCR=0: no carries ever; all outputs static.
- INCR changed while running: acc is not reset; the new increment applies from the next cycle, giving phase-continuous retuning.
- CLR write: on the next cycle acc=0, TICK_CNT=0, rtc_o=0, rtc_tick_o=0. A carry in the same cycle is discarded (CLR wins). CLR together with an EN write applies both; EN takes the written value.
- Read of TICK_CNT in the same cycle as an increment returns the pre-increment value.
- cke_i=0: every register, CSR writes included, holds. `iob_ready` stays 1 but accepted requests are dropped, so the system must not issue requests while cke_i=0.
- Reset asserted mid-operation: immediate return to reset values, with no glitch on rtc_o beyond the reset transition itself.

Decomposition:
- Package `iob_rtc_tick_gen_pkg`:
  - Word-offset constants CTRL_ADDR=0, INCR_ADDR=1, TICK_CNT_ADDR=2.
  - Bit indices CTRL_EN=0, CTRL_CLR=1.
  - Default ACC_W.
- Sub-module `iob_rtc_phase_acc`:
  - Inputs: en, clr, incr.
  - Outputs: carry pulse, rtc toggle, tick counter.
  - Contains the accumulator, output flops and tick counter.
- Top level: CSR decode and read mux only.

Test Plan:
- Reset, then read all four offsets -> rdata 0, INCR_RST, 0, 0 (INCR_RST=0); each rvalid exactly 1 cycle after its request; rtc_o=0.
- INCR=32'h4000_0000, EN=1 -> rtc_tick_o pulses every 4 cycles; rtc_o period 8 cycles; TICK_CNT=25 after 100 enabled cycles.
- INCR=32'h5555_5556 -> carry every 3 cycles, 33 ticks in 100 cycles (fractional path, no drift).
- Running at 32'h8000_0000, clear EN for 10 cycles, then set it again -> rtc_o and TICK_CNT frozen while disabled; rtc_tick_o resumes with the original phase.
- Write CLR on the exact cycle a carry is due -> no tick pulse; TICK_CNT reads 0; rtc_o=0; CTRL.CLR reads 0.
- Byte write wstrb=4'b0010, wdata=32'h0000_AB00 to INCR=32'h1234_5678 -> INCR reads 32'h1234_AB78; write to offset 3 -> reads 0. Then assert arst_i=0 mid-run -> all outputs return to reset values immediately.
